// File: rtl/rgu_fsm_if.sv
// Request-generator handshake bundle: header strobe/address in, arbiter and tail events in,
// request/lock vectors and status out.
interface rgu_fsm_if #(
  parameter int X_W = 4,
  parameter int Y_W = 4
);
  logic                 rqs_strobe;
  logic [X_W+Y_W-1:0]   addr;
  logic                 arb_ack;
  logic                 tail_done;
  logic [4:0]           rqs_vector;
  logic [4:0]           lock_vector;
  logic                 busy;
  logic                 rqs_urgent;
  logic                 addr_err;

  modport master (
    output rqs_strobe, addr, arb_ack, tail_done,
    input  rqs_vector, lock_vector, busy, rqs_urgent, addr_err
  );

  modport slave (
    input  rqs_strobe, addr, arb_ack, tail_done,
    output rqs_vector, lock_vector, busy, rqs_urgent, addr_err
  );
endinterface

// File: rtl/rgu_fsm.sv
// Route/request generator for one mesh router input port: dimension-order route from the
// header address, request held until granted, output port locked until the tail leaves.
module rgu_fsm #(
  parameter int X_W     = 4,
  parameter int Y_W     = 4,
  parameter int XCOR    = 2,
  parameter int YCOR    = 2,
  parameter int X_DIM   = 16,
  parameter int Y_DIM   = 16,
  parameter int MODE    = 0,
  parameter int AGE_MAX = 15
) (
  input  logic     clk,
  input  logic     rst,
  rgu_fsm_if.slave bus
);

  localparam int XW1 = X_W + 1;
  localparam int YW1 = Y_W + 1;
  localparam int AW  = $clog2(AGE_MAX + 1);

  localparam logic [XW1-1:0] X_HERE  = XW1'(XCOR);
  localparam logic [YW1-1:0] Y_HERE  = YW1'(YCOR);
  localparam logic [XW1-1:0] X_LIMIT = XW1'(X_DIM);
  localparam logic [YW1-1:0] Y_LIMIT = YW1'(Y_DIM);
  localparam logic [AW-1:0]  AGE_TOP = AW'(AGE_MAX);

  // Port encoding {PE,YNEG,YPOS,XNEG,XPOS}
  localparam logic [4:0] P_NONE = 5'b00000;
  localparam logic [4:0] P_XPOS = 5'b00001;
  localparam logic [4:0] P_XNEG = 5'b00010;
  localparam logic [4:0] P_YPOS = 5'b00100;
  localparam logic [4:0] P_YNEG = 5'b01000;
  localparam logic [4:0] P_PE   = 5'b10000;

  typedef enum logic [1:0] {IDLE, REQ, LOCK} state_e;

  state_e         state_q, state_d;
  logic [4:0]     rqs_q, rqs_d;
  logic [4:0]     lock_q, lock_d;
  logic [AW-1:0]  age_q, age_d;
  logic           urgent_q, urgent_d;
  logic           err_q, err_d;

  logic [X_W-1:0] dst_x;
  logic [Y_W-1:0] dst_y;
  logic [XW1-1:0] dx;
  logic [YW1-1:0] dy;
  logic           addr_ok;
  logic [4:0]     x_hop, y_hop, route;

  assign dst_x   = bus.addr[X_W+Y_W-1:Y_W];
  assign dst_y   = bus.addr[Y_W-1:0];
  assign dx      = {1'b0, dst_x} - X_HERE;
  assign dy      = {1'b0, dst_y} - Y_HERE;
  assign addr_ok = ({1'b0, dst_x} < X_LIMIT) && ({1'b0, dst_y} < Y_LIMIT);

  // NOTE: every combinational output gets a default first so no path can infer a latch.
  always_comb begin
    x_hop = P_NONE;
    y_hop = P_NONE;
    route = P_NONE;
    if (dx != '0) x_hop = dx[X_W] ? P_XNEG : P_XPOS;
    if (dy != '0) y_hop = dy[Y_W] ? P_YNEG : P_YPOS;
    if (addr_ok) begin
      if (MODE == 0) route = (x_hop != P_NONE) ? x_hop : (y_hop != P_NONE) ? y_hop : P_PE;
      else           route = (y_hop != P_NONE) ? y_hop : (x_hop != P_NONE) ? x_hop : P_PE;
    end
  end

  always_comb begin
    state_d = state_q;
    rqs_d   = rqs_q;
    lock_d  = lock_q;
    age_d   = age_q;
    err_d   = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (bus.rqs_strobe) begin
          if (addr_ok) begin
            rqs_d   = route;
            age_d   = '0;
            state_d = REQ;
          end else begin
            err_d = 1'b1;
          end
        end
      end
      REQ: begin
        if (bus.arb_ack) begin
          rqs_d = P_NONE;
          age_d = '0;
          // A single-flit packet is already gone, so there is nothing to lock.
          if (bus.tail_done) begin
            state_d = IDLE;
          end else begin
            lock_d  = rqs_q;
            state_d = LOCK;
          end
        end else if (age_q != AGE_TOP) begin
          age_d = age_q + AW'(1);
        end
      end
      LOCK: begin
        if (bus.tail_done) begin
          lock_d  = P_NONE;
          state_d = IDLE;
          if (bus.rqs_strobe) begin
            if (addr_ok) begin
              rqs_d   = route;
              age_d   = '0;
              state_d = REQ;
            end else begin
              err_d = 1'b1;
            end
          end
        end
      end
      default: begin
        state_d = IDLE;
        rqs_d   = P_NONE;
        lock_d  = P_NONE;
        age_d   = '0;
      end
    endcase
    urgent_d = (state_d == REQ) && (age_d == AGE_TOP);
  end

  // NOTE: sequential state uses non-blocking assignments so all flops update together.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= IDLE;
      rqs_q    <= P_NONE;
      lock_q   <= P_NONE;
      age_q    <= '0;
      urgent_q <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      rqs_q    <= rqs_d;
      lock_q   <= lock_d;
      age_q    <= age_d;
      urgent_q <= urgent_d;
      err_q    <= err_d;
    end
  end

  assign bus.rqs_vector  = rqs_q;
  assign bus.lock_vector = lock_q;
  assign bus.busy        = (state_q != IDLE);
  assign bus.rqs_urgent  = urgent_q;
  assign bus.addr_err    = err_q;

endmodule

// File: tb/tb_rgu_fsm.sv
// Directed bench for rgu_fsm: three instances (XY, YX, narrow X mesh) share one stimulus.
module tb_rgu_fsm;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       strobe = 1'b0;
  logic [7:0] addr = 8'h00;
  logic       ack = 1'b0;
  logic       tail = 1'b0;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  rgu_fsm_if #(.X_W(4), .Y_W(4)) if0 ();
  rgu_fsm_if #(.X_W(4), .Y_W(4)) if1 ();
  rgu_fsm_if #(.X_W(4), .Y_W(4)) if2 ();

  assign if0.rqs_strobe = strobe;
  assign if0.addr       = addr;
  assign if0.arb_ack    = ack;
  assign if0.tail_done  = tail;
  assign if1.rqs_strobe = strobe;
  assign if1.addr       = addr;
  assign if1.arb_ack    = ack;
  assign if1.tail_done  = tail;
  assign if2.rqs_strobe = strobe;
  assign if2.addr       = addr;
  assign if2.arb_ack    = ack;
  assign if2.tail_done  = tail;

  rgu_fsm #(.MODE(0)) u_xy (.clk(clk), .rst(rst), .bus(if0.slave));
  rgu_fsm #(.MODE(1)) u_yx (.clk(clk), .rst(rst), .bus(if1.slave));
  rgu_fsm #(.MODE(0), .X_DIM(4)) u_nx (.clk(clk), .rst(rst), .bus(if2.slave));

  task automatic check(input string tag, input logic [4:0] got, input logic [4:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s got %b expected %b", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    // Reset state
    #2 rst = 1'b0;
    #2;
    check("rst_rqs",    if0.rqs_vector, 5'b00000);
    check("rst_lock",   if0.lock_vector, 5'b00000);
    check("rst_busy",   {4'b0, if0.busy}, 5'd0);
    check("rst_urgent", {4'b0, if0.rqs_urgent}, 5'd0);
    check("rst_err",    {4'b0, if0.addr_err}, 5'd0);
    repeat (2) @(posedge clk);
    @(negedge clk) rst = 1'b1;

    // Local delivery, grant, tail
    strobe = 1'b1; addr = 8'h22;
    step(); strobe = 1'b0;
    check("pe_rqs",  if0.rqs_vector, 5'b10000);
    check("pe_busy", {4'b0, if0.busy}, 5'd1);
    check("pe_lock0", if0.lock_vector, 5'b00000);
    ack = 1'b1;
    step(); ack = 1'b0;
    check("pe_lock", if0.lock_vector, 5'b10000);
    check("pe_rqs_clr", if0.rqs_vector, 5'b00000);
    ack = 1'b1;
    step(); ack = 1'b0;
    check("lock_ack_ign", if0.lock_vector, 5'b10000);
    tail = 1'b1;
    step(); tail = 1'b0;
    check("tail_lock", if0.lock_vector, 5'b00000);
    check("tail_busy", {4'b0, if0.busy}, 5'd0);

    // Stray tail/ack in IDLE
    tail = 1'b1; ack = 1'b1;
    step(); tail = 1'b0; ack = 1'b0;
    check("idle_ign_busy", {4'b0, if0.busy}, 5'd0);
    check("idle_ign_err",  {4'b0, if0.addr_err}, 5'd0);

    // XY vs YX, then ageing with ack withheld
    strobe = 1'b1; addr = 8'h35;
    step(); strobe = 1'b0;
    check("xy_35", if0.rqs_vector, 5'b00001);
    check("yx_35", if1.rqs_vector, 5'b00100);
    check("nx_35", if2.rqs_vector, 5'b00001);
    for (int i = 1; i <= 20; i++) begin
      if (i == 3) begin strobe = 1'b1; addr = 8'h12; end
      step();
      strobe = 1'b0;
      check($sformatf("age_urgent_%0d", i), {4'b0, if0.rqs_urgent}, (i >= 15) ? 5'd1 : 5'd0);
      check($sformatf("age_rqs_%0d", i), if0.rqs_vector, 5'b00001);
    end
    ack = 1'b1;
    step(); ack = 1'b0;
    check("ack_urgent", {4'b0, if0.rqs_urgent}, 5'd0);
    check("ack_lock",   if0.lock_vector, 5'b00001);
    check("ack_rqs",    if0.rqs_vector, 5'b00000);

    // Back-to-back header on the tail cycle
    tail = 1'b1; strobe = 1'b1; addr = 8'h21;
    step(); tail = 1'b0; strobe = 1'b0;
    check("b2b_rqs",  if0.rqs_vector, 5'b01000);
    check("b2b_lock", if0.lock_vector, 5'b00000);
    check("b2b_busy", {4'b0, if0.busy}, 5'd1);

    // Single-flit packet: grant and tail together
    ack = 1'b1; tail = 1'b1;
    step(); ack = 1'b0; tail = 1'b0;
    check("sf_lock", if0.lock_vector, 5'b00000);
    check("sf_rqs",  if0.rqs_vector, 5'b00000);
    check("sf_busy", {4'b0, if0.busy}, 5'd0);
    step();
    check("sf_lock_after", if0.lock_vector, 5'b00000);

    // Westward route
    strobe = 1'b1; addr = 8'h12;
    step(); strobe = 1'b0;
    check("xy_12", if0.rqs_vector, 5'b00010);
    check("yx_12", if1.rqs_vector, 5'b00010);
    ack = 1'b1; tail = 1'b1;
    step(); ack = 1'b0; tail = 1'b0;

    // Out-of-mesh X on the narrow instance only
    strobe = 1'b1; addr = 8'h52;
    step(); strobe = 1'b0;
    check("oob_err",  {4'b0, if2.addr_err}, 5'd1);
    check("oob_rqs",  if2.rqs_vector, 5'b00000);
    check("oob_busy", {4'b0, if2.busy}, 5'd0);
    check("ok_err",   {4'b0, if0.addr_err}, 5'd0);
    check("ok_rqs",   if0.rqs_vector, 5'b00001);
    step();
    check("oob_pulse", {4'b0, if2.addr_err}, 5'd0);
    ack = 1'b1; tail = 1'b1;
    step(); ack = 1'b0; tail = 1'b0;

    // Asynchronous reset while locked
    strobe = 1'b1; addr = 8'h22;
    step(); strobe = 1'b0;
    ack = 1'b1;
    step(); ack = 1'b0;
    check("pre_rst_lock", if0.lock_vector, 5'b10000);
    #2 rst = 1'b0;
    #1;
    check("arst_lock", if0.lock_vector, 5'b00000);
    check("arst_rqs",  if0.rqs_vector, 5'b00000);
    check("arst_busy", {4'b0, if0.busy}, 5'd0);
    @(negedge clk);
    rst = 1'b1; ack = 1'b1;
    step(); ack = 1'b0;
    check("stale_lock", if0.lock_vector, 5'b00000);
    check("stale_busy", {4'b0, if0.busy}, 5'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
